mult_wb_arbiter: RTL
====================

# mult_wb_arbiter

Writeback arbiter that merges the one-cycle pipelined multiplier result stream and the serial divider result stream of the multiply/divide functional unit into a single writeback port. It sits directly downstream of the multiplier and the divider and upstream of the issue-stage writeback bus. Multiplier results always win the port. A conflicting divider result is parked in a one-entry hold register and back-pressures the divider. A starvation counter throttles new multiply issue so the parked divider result cannot wait forever.

## Interface
Parameters:
- CVA6Cfg, config_pkg::cva6_cfg_empty, core configuration; uses XLEN, TRANS_ID_BITS, NUM_THREADS_LOG
- StallLimit, 4, number of consecutive lost arbitrations a held divider result tolerates before multiply issue is blocked (1..15)

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  asynchronous reset, active-low
- flush_i  input  1  pipeline flush; discards held divider result
- mul_valid_i  input  1  multiplier result valid
- mul_result_i  input  XLEN  multiplier result
- mul_trans_id_i  input  TRANS_ID_BITS  multiplier transaction ID
- mul_thread_id_i  input  NUM_THREADS_LOG  multiplier thread ID
- div_valid_i  input  1  divider result valid
- div_ready_o  output  1  arbiter accepts divider result this cycle
- div_result_i  input  XLEN  divider result
- div_trans_id_i  input  TRANS_ID_BITS  divider transaction ID
- div_thread_id_i  input  NUM_THREADS_LOG  divider thread ID
- mul_block_o  output  1  issue must not dispatch new multiply ops
- wb_valid_o  output  1  writeback valid
- wb_result_o  output  XLEN  writeback data
- wb_trans_id_o  output  TRANS_ID_BITS  writeback transaction ID
- wb_thread_id_o  output  NUM_THREADS_LOG  writeback thread ID

## Operation
- State: hold_valid_q, hold_result_q, hold_trans_id_q, hold_thread_id_q, wait_cnt_q (4 bits, saturating at 15).
- Divider handshake:
  - A divider transfer occurs when div_valid_i && div_ready_o.
  - div_ready_o = !hold_valid_q. This is combinational from state only and never depends on div_valid_i.
- Output select, by priority:
  1. mul_valid_i: output the multiplier fields.
  2. hold_valid_q: output the held fields.
  3. div_valid_i && div_ready_o: bypass the divider fields directly to the output.
  4. Otherwise wb_valid_o = 0.
- The writeback port has no ready. Every wb_valid_o cycle is a completed writeback.
- Capture into the hold register: div transfer && mul_valid_i. Set hold_valid_q next cycle and latch the divider fields.
- Release the hold register: hold_valid_q && !mul_valid_i. Clear hold_valid_q next cycle.
  - Capture and release cannot coincide, because capture requires !hold_valid_q.
- Starvation counter:
  - wait_cnt_q increments when hold_valid_q && mul_valid_i.
  - It resets to 0 on release, flush, or capture.
- mul_block_o = hold_valid_q && (wait_cnt_q >= StallLimit). This is a registered-state function with no combinational path from inputs.
- Flush:
  - Clears hold_valid_q and wait_cnt_q next cycle.
  - Forces wb_valid_o = 0 and div_ready_o = 1 in the flush cycle; a divider transfer in that cycle is consumed and discarded.
- Data and ID fields of the output are don't-care when wb_valid_o = 0. They drive the multiplier fields by default.
- Behaviour on simultaneous mul_valid_i and a hold release is covered by the priority order: the multiplier wins and no release occurs.

## Timing
- Reset values:
  - wb_valid_o = 0, mul_block_o = 0, div_ready_o = 1.
  - hold_valid_q = 0, wait_cnt_q = 0, hold data = 0.
- Reset mid-operation discards any held divider result without writeback.
- Latency:
  - Multiplier: 0 cycles (combinational pass-through).
  - Divider with no conflict: 0 cycles (bypass).
  - Divider with conflict: at least 1 cycle, held until the first cycle with !mul_valid_i.
- Bounded wait: mul_block_o rises in cycle N. At most the multiply issued in cycle N-1 still returns, in cycle N. The held result therefore writes back no later than cycle N+1.
- A divider transfer is never lost except under flush or reset.
- At most one writeback per cycle. The divider never stalls the multiplier.

## Test plan
- Multiplier only: mul_valid_i = 1 with result 0x1234, trans_id 3 -> same cycle wb_valid_o = 1, wb_result_o = 0x1234, wb_trans_id_o = 3; div_ready_o stays 1.
- Divider bypass: div_valid_i = 1, result 0x55, trans_id 5, mul idle -> same cycle wb_result_o = 0x55, wb_trans_id_o = 5; hold_valid_q stays 0.
- Conflict: in cycle 0, mul result 0xA (id 1) and div result 0xB (id 2).
  - Cycle 0: writeback 0xA.
  - Cycle 1: div_ready_o = 0.
  - Cycle 1 with mul idle: writeback 0xB, id 2.
  - Cycle 2: div_ready_o = 1.
- Starvation, StallLimit = 4: conflict in cycle 0, then mul_valid_i held high continuously.
  - mul_block_o = 1 from cycle 5 (wait_cnt_q = 4).
  - Bench drops mul_valid_i from cycle 6.
  - Held result written in cycle 6; mul_block_o = 0 in cycle 7.
- Flush with held entry: hold_valid_q = 1, then flush_i for one cycle -> wb_valid_o = 0 that cycle; next cycle hold_valid_q = 0, div_ready_o = 1, and the held ID never appears on writeback.
- Async reset asserted while hold_valid_q = 1 and wait_cnt_q = 3 -> immediately wb_valid_o = 0, mul_block_o = 0, div_ready_o = 1; after release the first divider result bypasses normally.

Source files
------------

// File: rtl/config_pkg.sv
// Minimal core configuration: only the fields the mul/div writeback path consumes.
package config_pkg;

   typedef struct packed {
      int unsigned XLEN;
      int unsigned TRANS_ID_BITS;
      int unsigned NUM_THREADS_LOG;
   } cva6_cfg_t;

   localparam cva6_cfg_t cva6_cfg_empty = '{
      XLEN:            32'd32,
      TRANS_ID_BITS:   32'd3,
      NUM_THREADS_LOG: 32'd1
   };

endpackage

// File: rtl/mult_wb_arbiter.sv
// Merges the multiplier and divider result streams onto one writeback port.
// The multiplier always wins; a losing divider result is parked and throttles multiply issue.
module mult_wb_arbiter #(
   parameter config_pkg::cva6_cfg_t CVA6Cfg    = config_pkg::cva6_cfg_empty,
   parameter int unsigned           StallLimit = 4
) (
   input  logic                               clk_i,
   input  logic                               rst_ni,
   input  logic                               flush_i,
   input  logic                               mul_valid_i,
   input  logic [CVA6Cfg.XLEN-1:0]            mul_result_i,
   input  logic [CVA6Cfg.TRANS_ID_BITS-1:0]   mul_trans_id_i,
   input  logic [CVA6Cfg.NUM_THREADS_LOG-1:0] mul_thread_id_i,
   input  logic                               div_valid_i,
   output logic                               div_ready_o,
   input  logic [CVA6Cfg.XLEN-1:0]            div_result_i,
   input  logic [CVA6Cfg.TRANS_ID_BITS-1:0]   div_trans_id_i,
   input  logic [CVA6Cfg.NUM_THREADS_LOG-1:0] div_thread_id_i,
   output logic                               mul_block_o,
   output logic                               wb_valid_o,
   output logic [CVA6Cfg.XLEN-1:0]            wb_result_o,
   output logic [CVA6Cfg.TRANS_ID_BITS-1:0]   wb_trans_id_o,
   output logic [CVA6Cfg.NUM_THREADS_LOG-1:0] wb_thread_id_o
);

   localparam int unsigned XLEN  = CVA6Cfg.XLEN;
   localparam int unsigned TidW  = CVA6Cfg.TRANS_ID_BITS;
   localparam int unsigned ThrW  = CVA6Cfg.NUM_THREADS_LOG;
   localparam int unsigned CntW  = 4;
   localparam logic [CntW-1:0] CntMax = '1;
   localparam logic [CntW-1:0] Limit  = CntW'(StallLimit);

   logic            r_hold_valid;
   logic [XLEN-1:0] r_hold_result;
   logic [TidW-1:0] r_hold_trans_id;
   logic [ThrW-1:0] r_hold_thread_id;
   logic [CntW-1:0] r_wait_cnt;

   logic            w_hold_valid_d;
   logic [XLEN-1:0] w_hold_result_d;
   logic [TidW-1:0] w_hold_trans_id_d;
   logic [ThrW-1:0] w_hold_thread_id_d;
   logic [CntW-1:0] w_wait_cnt_d;

   logic w_div_xfer;
   logic w_capture;
   logic w_release;

   // Flush opens the divider port so an in-flight result is consumed and dropped.
   assign div_ready_o = !r_hold_valid || flush_i;
   assign w_div_xfer  = div_valid_i && div_ready_o;
   assign w_capture   = w_div_xfer && mul_valid_i && !flush_i;
   assign w_release   = r_hold_valid && !mul_valid_i;
   assign mul_block_o = r_hold_valid && (r_wait_cnt >= Limit);

   // Writeback select: multiplier, then held divider result, then divider bypass.
   always_comb begin
      wb_valid_o     = 1'b0;
      wb_result_o    = mul_result_i;
      wb_trans_id_o  = mul_trans_id_i;
      wb_thread_id_o = mul_thread_id_i;
      if (!flush_i) begin
         if (mul_valid_i) begin
            wb_valid_o = 1'b1;
         end else if (r_hold_valid) begin
            wb_valid_o     = 1'b1;
            wb_result_o    = r_hold_result;
            wb_trans_id_o  = r_hold_trans_id;
            wb_thread_id_o = r_hold_thread_id;
         end else if (w_div_xfer) begin
            wb_valid_o     = 1'b1;
            wb_result_o    = div_result_i;
            wb_trans_id_o  = div_trans_id_i;
            wb_thread_id_o = div_thread_id_i;
         end
      end
   end

   // Hold register and starvation counter next state.
   always_comb begin
      w_hold_valid_d     = r_hold_valid;
      w_hold_result_d    = r_hold_result;
      w_hold_trans_id_d  = r_hold_trans_id;
      w_hold_thread_id_d = r_hold_thread_id;
      w_wait_cnt_d       = r_wait_cnt;
      if (flush_i) begin
         w_hold_valid_d = 1'b0;
         w_wait_cnt_d   = '0;
      end else if (w_capture) begin
         w_hold_valid_d     = 1'b1;
         w_hold_result_d    = div_result_i;
         w_hold_trans_id_d  = div_trans_id_i;
         w_hold_thread_id_d = div_thread_id_i;
         w_wait_cnt_d       = '0;
      end else if (w_release) begin
         w_hold_valid_d = 1'b0;
         w_wait_cnt_d   = '0;
      end else if (r_hold_valid && mul_valid_i && (r_wait_cnt != CntMax)) begin
         w_wait_cnt_d = r_wait_cnt + CntW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_hold_valid     <= 1'b0;
         r_hold_result    <= '0;
         r_hold_trans_id  <= '0;
         r_hold_thread_id <= '0;
         r_wait_cnt       <= '0;
      end else begin
         r_hold_valid     <= w_hold_valid_d;
         r_hold_result    <= w_hold_result_d;
         r_hold_trans_id  <= w_hold_trans_id_d;
         r_hold_thread_id <= w_hold_thread_id_d;
         r_wait_cnt       <= w_wait_cnt_d;
      end
   end

endmodule
